fetch_ctrl: RTL and testbench

Dual-issue fetch controller that sequences the two-wide instruction ROM. It owns the fetch PC, drives the ROM word address, and tracks the ROM's one-cycle registered read latency. Returned instruction pairs are buffered in a small queue with a valid/ready handshake to decode. The block also handles redirects from branch/JAL resolution and wrap-around at the end of the ROM. It sits between the ROM and the decode/hazard stage of the superscalar front end.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 66 ++++++
 rtl/fetch_ctrl.sv | 114 +++++++++++
 tb/tb_fetch_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the dual-issue fetch front end: the NOP encoding
// and the layout of one fetch-queue entry (one instruction pair).
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam int PC_W     = 32;
   localparam int INSTR_W  = 32;
   localparam int VALID2_W = 1;
   localparam int ENTRY_W  = PC_W + 2 * INSTR_W + VALID2_W;

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr1;
      logic [INSTR_W-1:0] instr2;
      logic               valid2;
   } fetch_entry_t;

   // What decode sees while the queue is empty: the reset-value pair.
   localparam fetch_entry_t EMPTY_ENTRY = '{
      pc:     '0,
      instr1: NOP_INSTR,
      instr2: NOP_INSTR,
      valid2: 1'b0
   };

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of instruction pairs between the ROM return path
// and decode. Flush empties it in one cycle; the head is read straight from
// storage so nothing from the ROM reaches decode combinationally.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             push_i,
   input  fetch_entry_t     push_data_i,
   input  logic             pop_i,
   output fetch_entry_t     head_o,
   output logic             head_valid_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] rdPtr_q;
   logic [PTR_W-1:0] wrPtr_q;
   logic [CNT_W-1:0] count_q;
   logic             doPop;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign doPop        = pop_i && (count_q != '0);
   assign head_valid_o = (count_q != '0);
   assign head_o       = head_valid_o ? mem_q[rdPtr_q] : EMPTY_ENTRY;
   assign count_o      = count_q;

   // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            wrPtr_q <= nextPtr(wrPtr_q);
         end
         if (doPop) begin
            rdPtr_q <= nextPtr(rdPtr_q);
         end
         count_q <= count_q + CNT_W'(push_i) - CNT_W'(doPop);
      end
   end

   // Entry storage is write-only state; it needs no reset because count gates it.
   always_ff @(posedge clk) begin
      if (!rst && !flush_i && push_i) begin
         mem_q[wrPtr_q] <= push_data_i;
      end
   end

   // The fetch side throttles issue so a push into a full queue needs a same-cycle pop.
   assert property (@(posedge clk) disable iff (rst)
      !(push_i && !flush_i && !pop_i && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/fetch_ctrl.sv
// Dual-issue fetch controller: owns the fetch PC, drives the two-word ROM,
// tracks the one-cycle ROM latency and feeds returned pairs into the fetch
// queue. Redirects flush everything and restart at the new word; the last
// ROM word is fetched alone and fetch wraps back to word 0.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int          ADDR_W   = 10,
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_instr1,
   input  logic [31:0]       rom_instr2,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_instr1,
   output logic [31:0]       out_instr2,
   output logic              out_valid2
);

   localparam int                CNT_W      = $clog2(DEPTH + 1);
   localparam logic [ADDR_W-1:0] LAST_WORD  = '1;
   localparam logic [ADDR_W-1:0] RESET_WORD = RESET_PC[ADDR_W+1:2];

   logic [ADDR_W-1:0] pcWord_q, pcWord_d;
   logic              inflight_q, inflight_d;
   logic              inflightKill_q, inflightKill_d;
   logic [ADDR_W-1:0] inflightWord_q, inflightWord_d;
   logic              inflightSingle_q, inflightSingle_d;

   logic [CNT_W-1:0]  count;
   logic [CNT_W:0]    occupancy;
   logic              pop;
   logic              push;
   logic              issue;
   fetch_entry_t      pushEntry;
   fetch_entry_t      head;
   logic              headValid;
   logic              unusedRedirectBits;

   assign unusedRedirectBits = ^{redirect_pc[31:ADDR_W+2], redirect_pc[1:0]};

   assign rom_addr  = pcWord_q;
   assign pop       = headValid && out_ready;
   assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
   assign issue     = !rst && !redirect_valid && (occupancy < (CNT_W + 1)'(DEPTH));
   assign push      = inflight_q && !inflightKill_q && !redirect_valid;

   assign pushEntry.pc     = 32'({inflightWord_q, 2'b00});
   assign pushEntry.instr1 = rom_instr1;
   assign pushEntry.instr2 = inflightSingle_q ? NOP_INSTR : rom_instr2;
   assign pushEntry.valid2 = !inflightSingle_q;

   // Next fetch PC and in-flight request tracking; a redirect overrides issue.
   always_comb begin
      pcWord_d         = pcWord_q;
      inflight_d       = issue;
      inflightKill_d   = redirect_valid;
      inflightWord_d   = inflightWord_q;
      inflightSingle_d = inflightSingle_q;
      if (redirect_valid) begin
         pcWord_d = redirect_pc[ADDR_W+1:2];
      end else if (issue) begin
         inflightWord_d   = pcWord_q;
         inflightSingle_d = (pcWord_q == LAST_WORD);
         pcWord_d         = (pcWord_q == LAST_WORD) ? '0 : pcWord_q + ADDR_W'(2);
      end
   end

   // Fetch state registers with synchronous reset to the boot PC.
   always_ff @(posedge clk) begin
      if (rst) begin
         pcWord_q         <= RESET_WORD;
         inflight_q       <= 1'b0;
         inflightKill_q   <= 1'b0;
         inflightWord_q   <= '0;
         inflightSingle_q <= 1'b0;
      end else begin
         pcWord_q         <= pcWord_d;
         inflight_q       <= inflight_d;
         inflightKill_q   <= inflightKill_d;
         inflightWord_q   <= inflightWord_d;
         inflightSingle_q <= inflightSingle_d;
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) uQueue (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (redirect_valid),
      .push_i       (push),
      .push_data_i  (pushEntry),
      .pop_i        (pop),
      .head_o       (head),
      .head_valid_o (headValid),
      .count_o      (count)
   );

   assign out_valid  = headValid;
   assign out_pc     = head.pc;
   assign out_instr1 = head.instr1;
   assign out_instr2 = head.instr2;
   assign out_valid2 = head.valid2;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a table of single-cycle vectors for the
// reset/startup stream, then hand-written sequences for stall, redirect,
// ROM wrap-around and mid-stream reset.
module tb_fetch_ctrl;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  rom_addr;
   logic [31:0] rom_instr1;
   logic [31:0] rom_instr2;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr1;
   logic [31:0] out_instr2;
   logic        out_valid2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic        redir;
      logic [31:0] rpc;
      logic        ready;
      logic        expValid;
      logic [31:0] expPc;
      logic [31:0] expI1;
      logic [31:0] expI2;
      logic        expV2;
      logic [9:0]  expAddr;
   } vec_t;

   vec_t vecs [7];

   fetch_ctrl #(
      .ADDR_W   (10),
      .DEPTH    (4),
      .RESET_PC (32'h0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .rom_addr       (rom_addr),
      .rom_instr1     (rom_instr1),
      .rom_instr2     (rom_instr2),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr1     (out_instr1),
      .out_instr2     (out_instr2),
      .out_valid2     (out_valid2)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // ROM model: word i holds BASE+i, one-cycle registered read of words addr and addr+1.
   always @(posedge clk) begin
      rom_instr1 <= BASE + {22'd0, rom_addr};
      rom_instr2 <= BASE + {22'd0, 10'(rom_addr + 10'd1)};
   end

   // Safety net so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   task automatic applyStimulus(input logic r, input logic rd, input logic [31:0] p, input logic rdy);
      rst            = r;
      redirect_valid = rd;
      redirect_pc    = p;
      out_ready      = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic checkAddr(input string name, input logic [9:0] exp);
      checkWord({name, ".rom_addr"}, {22'd0, rom_addr}, {22'd0, exp});
   endtask

   task automatic checkOutput(input string name, input logic expValid, input logic [31:0] expPc,
                              input logic [31:0] expI1, input logic [31:0] expI2, input logic expV2);
      checkWord({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, expValid});
      if (expValid) begin
         checkWord({name, ".out_pc"}, out_pc, expPc);
         checkWord({name, ".out_instr1"}, out_instr1, expI1);
         checkWord({name, ".out_instr2"}, out_instr2, expI2);
         checkWord({name, ".out_valid2"}, {31'd0, out_valid2}, {31'd0, expV2});
      end
   endtask

   task automatic checkReset(input string name);
      checkWord({name, ".out_valid"}, {31'd0, out_valid}, 32'd0);
      checkWord({name, ".out_valid2"}, {31'd0, out_valid2}, 32'd0);
      checkWord({name, ".out_pc"}, out_pc, 32'd0);
      checkWord({name, ".out_instr1"}, out_instr1, NOP);
      checkWord({name, ".out_instr2"}, out_instr2, NOP);
      checkAddr(name, 10'd0);
   endtask

   // Main test sequence.
   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      out_ready      = 1'b1;

      // Startup stream: cycle 0 is the first cycle after reset; first pair at cycle 2.
      vecs[0] = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0,  NOP,          NOP,          1'b0, 10'd0};
      vecs[1] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0,  NOP,          NOP,          1'b0, 10'd2};
      vecs[2] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd0,  32'h10000000, 32'h10000001, 1'b1, 10'd4};
      vecs[3] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd8,  32'h10000002, 32'h10000003, 1'b1, 10'd6};
      vecs[4] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd16, 32'h10000004, 32'h10000005, 1'b1, 10'd8};
      vecs[5] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd24, 32'h10000006, 32'h10000007, 1'b1, 10'd10};
      vecs[6] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd32, 32'h10000008, 32'h10000009, 1'b1, 10'd12};

      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
         if (vecs[i].rst) begin
            checkReset($sformatf("vec%0d", i));
         end else begin
            checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expPc,
                        vecs[i].expI1, vecs[i].expI2, vecs[i].expV2);
            checkAddr($sformatf("vec%0d", i), vecs[i].expAddr);
         end
      end

      // Stall from cycle 2 for 10 cycles: four pairs queued, fetch parks at word 8.
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
      checkReset("stall_reset");
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      for (int c = 2; c <= 11; c++) begin
         applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
         checkOutput($sformatf("stall_hold_c%0d", c + 1), 1'b1, 32'd0, 32'h10000000, 32'h10000001, 1'b1);
         if (c + 1 >= 5) begin
            checkAddr($sformatf("stall_park_c%0d", c + 1), 10'd8);
         end
      end
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
         checkOutput($sformatf("release%0d", i), 1'b1, 32'(8 * i), BASE + 32'(2 * i),
                     BASE + 32'(2 * i + 1), 1'b1);
      end

      // Fill the queue, then redirect to 0x104 while full.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
      end
      applyStimulus(1'b0, 1'b1, 32'h0000_0104, 1'b0);
      checkOutput("redir_full_n1", 1'b0, 32'd0, NOP, NOP, 1'b0);
      checkAddr("redir_full_n1", 10'h041);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("redir_full_n2", 1'b0, 32'd0, NOP, NOP, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("redir_full_n3", 1'b1, 32'h104, 32'h10000041, 32'h10000042, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("redir_full_n4", 1'b1, 32'h10C, 32'h10000043, 32'h10000044, 1'b1);

      // Redirect to word 1022 (high and low junk bits set): full pair, then wrap to 0.
      applyStimulus(1'b0, 1'b1, 32'h7000_0FF9, 1'b1);
      checkOutput("wrap22_n1", 1'b0, 32'd0, NOP, NOP, 1'b0);
      checkAddr("wrap22_n1", 10'd1022);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("wrap22_n2", 1'b0, 32'd0, NOP, NOP, 1'b0);
      checkAddr("wrap22_n2", 10'd0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("wrap22_n3", 1'b1, 32'hFF8, 32'h100003FE, 32'h100003FF, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("wrap22_n4", 1'b1, 32'h0, 32'h10000000, 32'h10000001, 1'b1);

      // Redirect to word 1023: single-instruction pair, then wrap to 0.
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
      checkOutput("wrap23_n1", 1'b0, 32'd0, NOP, NOP, 1'b0);
      checkAddr("wrap23_n1", 10'd1023);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("wrap23_n2", 1'b0, 32'd0, NOP, NOP, 1'b0);
      checkAddr("wrap23_n2", 10'd0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("wrap23_n3", 1'b1, 32'hFFC, 32'h100003FF, NOP, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("wrap23_n4", 1'b1, 32'h0, 32'h10000000, 32'h10000001, 1'b1);

      // Redirect in a cycle with a ROM return and a pop: returned pair must vanish.
      applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b1);
      checkOutput("redir_pop_n1", 1'b0, 32'd0, NOP, NOP, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("redir_pop_n2", 1'b0, 32'd0, NOP, NOP, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("redir_pop_n3", 1'b1, 32'h200, 32'h10000080, 32'h10000081, 1'b1);

      // One-cycle reset mid-stream: reset values next cycle, restart with 2-cycle latency.
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
      checkReset("midrst");
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("midrst_c1", 1'b0, 32'd0, NOP, NOP, 1'b0);
      checkAddr("midrst_c1", 10'd2);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
      checkOutput("midrst_c2", 1'b1, 32'd0, 32'h10000000, 32'h10000001, 1'b1);
      checkAddr("midrst_c2", 10'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
